// File: rtl/touch_sample_scheduler_if.sv
// Scheduler bus: ADC engine transaction handshake plus the averaged coordinate output.
// The master modport is the scheduler; slave is the engine/consumer side.
interface touch_sample_scheduler_if;
  localparam int unsigned DATA_W = 12;

  logic              start;
  logic              done;
  logic [DATA_W-1:0] x_raw;
  logic [DATA_W-1:0] y_raw;
  logic [DATA_W-1:0] x_coord;
  logic [DATA_W-1:0] y_coord;
  logic              valid;
  logic              ready;
  logic              pen_down;
  logic              timeout;

  modport master (
    output start, x_coord, y_coord, valid, pen_down, timeout,
    input  done, x_raw, y_raw, ready
  );

  modport slave (
    input  start, x_coord, y_coord, valid, pen_down, timeout,
    output done, x_raw, y_raw, ready
  );
endinterface

// File: rtl/touch_sample_scheduler.sv
// Touch-panel sample scheduler: debounces pen-down, paces X/Y transactions,
// averages 2^AVG_LOG2 samples and presents them on a valid/ready handshake.
module touch_sample_scheduler #(
  parameter int unsigned SYSCLK_FRQ   = 50000000,
  parameter int unsigned SAMPLE_HZ    = 200,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned AVG_LOG2     = 2,
  parameter int unsigned TIMEOUT_CYC  = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pen_irq_n,
  touch_sample_scheduler_if.master   bus
);

  localparam int unsigned DATA_W   = 12;
  localparam int unsigned TICK_CNT = SYSCLK_FRQ / SAMPLE_HZ;
  localparam int unsigned N_AVG    = 1 << AVG_LOG2;
  localparam int unsigned ACC_W    = DATA_W + AVG_LOG2;
  localparam int unsigned SCNT_W   = AVG_LOG2 + 1;
  localparam int unsigned DEB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TICK_W   = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int unsigned TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_WAIT_TICK,
    S_CONVERT,
    S_PRESENT
  } state_t;

  state_t              state, state_next;
  logic                pen_m, pen_s;
  logic [DEB_W-1:0]    deb_cnt, deb_cnt_next;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_next;
  logic [TO_W-1:0]     to_cnt, to_cnt_next;
  logic [ACC_W-1:0]    acc_x, acc_x_next, acc_y, acc_y_next;
  logic [ACC_W-1:0]    sum_x, sum_y;
  logic [SCNT_W-1:0]   smp_cnt, smp_cnt_next, smp_inc;
  logic                lifted, lifted_next, lifted_now;
  logic                start_next, valid_next, pen_down_next, timeout_next;
  logic [DATA_W-1:0]   x_coord_next, y_coord_next;

  // Two-flop synchroniser; reset to "pen up" so reset never looks like a touch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_m <= 1'b1;
      pen_s <= 1'b1;
    end else begin
      pen_m <= pen_irq_n;
      pen_s <= pen_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      deb_cnt      <= '0;
      tick_cnt     <= '0;
      to_cnt       <= '0;
      acc_x        <= '0;
      acc_y        <= '0;
      smp_cnt      <= '0;
      lifted       <= 1'b0;
      bus.start    <= 1'b0;
      bus.valid    <= 1'b0;
      bus.pen_down <= 1'b0;
      bus.timeout  <= 1'b0;
      bus.x_coord  <= '0;
      bus.y_coord  <= '0;
    end else begin
      state        <= state_next;
      deb_cnt      <= deb_cnt_next;
      tick_cnt     <= tick_cnt_next;
      to_cnt       <= to_cnt_next;
      acc_x        <= acc_x_next;
      acc_y        <= acc_y_next;
      smp_cnt      <= smp_cnt_next;
      lifted       <= lifted_next;
      bus.start    <= start_next;
      bus.valid    <= valid_next;
      bus.pen_down <= pen_down_next;
      bus.timeout  <= timeout_next;
      bus.x_coord  <= x_coord_next;
      bus.y_coord  <= y_coord_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next    = state;
    deb_cnt_next  = deb_cnt;
    tick_cnt_next = tick_cnt;
    to_cnt_next   = to_cnt;
    acc_x_next    = acc_x;
    acc_y_next    = acc_y;
    smp_cnt_next  = smp_cnt;
    lifted_next   = lifted;
    lifted_now    = lifted;
    start_next    = 1'b0;
    valid_next    = bus.valid;
    timeout_next  = bus.timeout;
    x_coord_next  = bus.x_coord;
    y_coord_next  = bus.y_coord;
    sum_x         = acc_x + ACC_W'(bus.x_raw);
    sum_y         = acc_y + ACC_W'(bus.y_raw);
    smp_inc       = smp_cnt + SCNT_W'(1);

    unique case (state)
      S_IDLE: begin
        if (!pen_s) begin
          state_next   = S_DEBOUNCE;
          deb_cnt_next = '0;
        end
      end

      S_DEBOUNCE: begin
        if (pen_s) begin
          state_next = S_IDLE;
        end else if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
          state_next    = S_WAIT_TICK;
          tick_cnt_next = '0;
          acc_x_next    = '0;
          acc_y_next    = '0;
          smp_cnt_next  = '0;
        end else begin
          deb_cnt_next = deb_cnt + DEB_W'(1);
        end
      end

      S_WAIT_TICK: begin
        if (pen_s) begin
          state_next   = S_IDLE;
          acc_x_next   = '0;
          acc_y_next   = '0;
          smp_cnt_next = '0;
        end else if (tick_cnt == TICK_W'(TICK_CNT - 1)) begin
          state_next  = S_CONVERT;
          start_next  = 1'b1;
          to_cnt_next = '0;
          lifted_next = 1'b0;
        end else begin
          tick_cnt_next = tick_cnt + TICK_W'(1);
        end
      end

      // A lift is remembered and acted on when the engine completes.
      S_CONVERT: begin
        lifted_now  = lifted | pen_s;
        lifted_next = lifted_now;
        if (bus.done) begin
          if (lifted_now) begin
            state_next   = S_IDLE;
            acc_x_next   = '0;
            acc_y_next   = '0;
            smp_cnt_next = '0;
          end else if (smp_inc == SCNT_W'(N_AVG)) begin
            state_next   = S_PRESENT;
            acc_x_next   = sum_x;
            acc_y_next   = sum_y;
            smp_cnt_next = smp_inc;
            valid_next   = 1'b1;
            x_coord_next = DATA_W'(sum_x >> AVG_LOG2);
            y_coord_next = DATA_W'(sum_y >> AVG_LOG2);
          end else begin
            state_next    = S_WAIT_TICK;
            acc_x_next    = sum_x;
            acc_y_next    = sum_y;
            smp_cnt_next  = smp_inc;
            tick_cnt_next = '0;
          end
        end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state_next   = S_IDLE;
          timeout_next = 1'b1;
          acc_x_next   = '0;
          acc_y_next   = '0;
          smp_cnt_next = '0;
        end else begin
          to_cnt_next = to_cnt + TO_W'(1);
        end
      end

      S_PRESENT: begin
        if (bus.ready) begin
          valid_next    = 1'b0;
          timeout_next  = 1'b0;
          acc_x_next    = '0;
          acc_y_next    = '0;
          smp_cnt_next  = '0;
          tick_cnt_next = '0;
          state_next    = pen_s ? S_IDLE : S_WAIT_TICK;
        end
      end

      default: state_next = S_IDLE;
    endcase

    pen_down_next = (state_next == S_WAIT_TICK) || (state_next == S_CONVERT) ||
                    (state_next == S_PRESENT);
  end

endmodule
